// File: rtl/mem_stage_dmem_ctrl.sv
// mem_stage_dmem_ctrl: MEM-stage data-memory controller for the RV32I pipeline.
// Issues one byte-lane aligned cache access at a time, stalls the pipeline
// while the cache is busy and returns the extended load result.
// Optional feature macro: MEM_MISALIGN_CHECK_EN (flags misaligned half/word
// accesses and completes them without touching the cache).
module mem_stage_dmem_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_i,
  input  logic        is_load_i,
  input  logic        is_store_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] rs2_data_i,
  input  logic        fwd_i,
  input  logic [31:0] wb_data_i,
  output logic        dmem_read,
  output logic        dmem_write,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_mbe,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_resp,
  output logic        stall_o,
  output logic [31:0] load_data_o,
  output logic        load_valid_o,
  output logic        misalign_o
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state_reg, state_next;
  logic        req;
  logic        misaligned;
  logic [31:0] store_src;
  logic [31:0] lane_wdata;
  logic [3:0]  lane_mbe;

  logic        load_reg;
  logic [2:0]  funct3_reg;
  logic [1:0]  off_reg;
  logic        read_reg, write_reg;
  logic [31:0] addr_reg, wdata_reg, load_data_reg;
  logic [3:0]  mbe_reg;
  logic        load_valid_reg, misalign_reg;

  logic [31:0] rd_byte_shift, rd_half_shift, load_ext;

  assign req = valid_i & (is_load_i | is_store_i);

`ifdef MEM_MISALIGN_CHECK_EN
  // Half with odd address or word not on a 4-byte boundary.
  assign misaligned = ((funct3_i[1:0] == 2'b01) & addr_i[0]) |
                      ((funct3_i[1:0] == 2'b10) & (addr_i[1:0] != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  // Store data source selection and byte-lane placement of the request.
  always_comb begin
    store_src  = fwd_i ? wb_data_i : rs2_data_i;
    lane_mbe   = 4'b1111;
    lane_wdata = store_src;
    case (funct3_i[1:0])
      2'b00: begin
        lane_mbe   = 4'b0001 << addr_i[1:0];
        lane_wdata = {4{store_src[7:0]}};
      end
      2'b01: begin
        lane_mbe   = 4'b0011 << {addr_i[1], 1'b0};
        lane_wdata = {2{store_src[15:0]}};
      end
      default: begin
        lane_mbe   = 4'b1111;
        lane_wdata = store_src;
      end
    endcase
    if (is_load_i) begin
      lane_mbe = 4'b1111;
    end
  end

  // Load extraction from the returned word using the latched offset/width.
  always_comb begin
    rd_byte_shift = dmem_rdata >> {off_reg, 3'b000};
    rd_half_shift = dmem_rdata >> {off_reg[1], 4'b0000};
    case (funct3_reg)
      3'b000:  load_ext = {{24{rd_byte_shift[7]}}, rd_byte_shift[7:0]};
      3'b100:  load_ext = {24'b0, rd_byte_shift[7:0]};
      3'b001:  load_ext = {{16{rd_half_shift[15]}}, rd_half_shift[15:0]};
      3'b101:  load_ext = {16'b0, rd_half_shift[15:0]};
      default: load_ext = dmem_rdata;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state decode and combinational pipeline stall.
  always_comb begin
    state_next = state_reg;
    stall_o    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (req) begin
          stall_o    = 1'b1;
          state_next = misaligned ? DONE : BUSY;
        end
      end
      BUSY: begin
        stall_o = 1'b1;
        if (dmem_resp) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Request latch, cache strobes and load result capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      load_reg       <= 1'b0;
      funct3_reg     <= 3'b000;
      off_reg        <= 2'b00;
      read_reg       <= 1'b0;
      write_reg      <= 1'b0;
      addr_reg       <= 32'b0;
      wdata_reg      <= 32'b0;
      mbe_reg        <= 4'b0000;
      load_data_reg  <= 32'b0;
      load_valid_reg <= 1'b0;
      misalign_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          load_valid_reg <= 1'b0;
          misalign_reg   <= 1'b0;
          if (req) begin
            load_reg   <= is_load_i;
            funct3_reg <= funct3_i;
            off_reg    <= addr_i[1:0];
            addr_reg   <= {addr_i[31:2], 2'b00};
            wdata_reg  <= lane_wdata;
            mbe_reg    <= lane_mbe;
            if (misaligned) begin
              // Completes straight into DONE with no cache traffic.
              misalign_reg   <= 1'b1;
              load_valid_reg <= is_load_i;
              if (is_load_i) begin
                load_data_reg <= 32'b0;
              end
            end else begin
              read_reg  <= is_load_i;
              write_reg <= ~is_load_i;
            end
          end
        end
        BUSY: begin
          if (dmem_resp) begin
            read_reg  <= 1'b0;
            write_reg <= 1'b0;
            if (load_reg) begin
              load_data_reg  <= load_ext;
              load_valid_reg <= 1'b1;
            end
          end
        end
        default: begin
          load_valid_reg <= 1'b0;
          misalign_reg   <= 1'b0;
        end
      endcase
    end
  end

  assign dmem_read    = read_reg;
  assign dmem_write   = write_reg;
  assign dmem_addr    = addr_reg;
  assign dmem_wdata   = wdata_reg;
  assign dmem_mbe     = mbe_reg;
  assign load_data_o  = load_data_reg;
  assign load_valid_o = load_valid_reg;
  assign misalign_o   = misalign_reg;

endmodule

// File: doc/mem_stage_dmem_ctrl.md
# mem_stage_dmem_ctrl

MEM-stage data-memory controller for the 5-stage RV32I pipeline, directly downstream of the memory forwarding unit. It consumes the EX/MEM load/store request and the forward select, and produces the following outputs:
- the byte-lane aligned cache request;
- a pipeline stall while the cache is busy;
- the extracted, sign/zero-extended load result for the MEM/WB register.

Only one access is outstanding at a time.

## Interface
Parameters:
- none; data and address widths are fixed at 32 (rv32i_word).

Ports:
- clk  in  1  pipeline clock
- rst  in  1  reset, synchronous, active-high
- valid_i  in  1  EX/MEM holds a valid instruction
- is_load_i  in  1  EX/MEM opcode is op_load
- is_store_i  in  1  EX/MEM opcode is op_store
- funct3_i  in  3  load/store width code (000 B, 001 H, 010 W, 100 BU, 101 HU)
- addr_i  in  32  effective byte address from EX/MEM ALU result
- rs2_data_i  in  32  store data from EX/MEM
- fwd_i  in  1  forwarding unit select: store data taken from wb_data_i instead of rs2_data_i
- wb_data_i  in  32  MEM/WB writeback value (load result of the older instruction)
- dmem_read  out  1  cache read strobe
- dmem_write  out  1  cache write strobe
- dmem_addr  out  32  word-aligned address, {addr[31:2],2'b00}
- dmem_wdata  out  32  lane-aligned store data
- dmem_mbe  out  4  byte enables
- dmem_rdata  in  32  cache read data, valid with dmem_resp
- dmem_resp  in  1  cache completion, one-cycle pulse
- stall_o  out  1  freeze PC/IF/ID/EX/MEM registers
- load_data_o  out  32  extended load result
- load_valid_o  out  1  load_data_o valid this cycle
- misalign_o  out  1  misaligned access flagged (see Configuration)

## Operation
- FSM states: IDLE, BUSY, DONE. Reset state is IDLE.
- Request condition: req = valid_i & (is_load_i | is_store_i).
- IDLE, req=1:
  - latch the direction, funct3, addr_i, store source and mbe;
  - move to BUSY.
- IDLE, req=0: stay in IDLE.
- BUSY:
  - dmem_read = latched load, or dmem_write = latched store; exactly one is high;
  - dmem_addr, dmem_wdata and dmem_mbe are held constant;
  - on dmem_resp: capture dmem_rdata, move to DONE.
- DONE:
  - held for one cycle; stall_o=0 so the pipeline advances;
  - load_valid_o=1 if the access was a load;
  - next state is IDLE. The instruction that advanced is never re-issued.
- stall_o = (IDLE & req) | BUSY. It is combinational and low in DONE.
- Store source: fwd_i ? wb_data_i : rs2_data_i, sampled at the IDLE→BUSY transition.
- Byte lanes, with o = addr[1:0]:
  - SB: mbe = 4'b0001<<o; wdata = byte replicated 4×.
  - SH: mbe = 4'b0011<<(2·o[1]); wdata = half replicated 2×.
  - SW: mbe = 4'b1111; wdata = data unchanged.
  - Loads: mbe = 4'b1111.
- Load extract, using the latched o:
  - LB/LBU: byte = rdata[8o+7:8o].
  - LH/LHU: half = rdata[16o[1]+15:16o[1]].
  - LW: full word.
  - LB/LH sign-extend; LBU/LHU zero-extend.
- dmem_resp arriving in IDLE or DONE is ignored.

## Timing
- Reset values:
  - FSM = IDLE;
  - dmem_read, dmem_write, load_valid_o, misalign_o = 0;
  - dmem_addr, dmem_wdata, load_data_o = 0;
  - dmem_mbe = 4'b0000.
- Cycle sequence:
  - cycle 0: req seen in IDLE;
  - cycle 1: strobe high (registered);
  - resp at cycle k≥1;
  - cycle k+1: DONE.
- Minimum is 2 stall cycles plus 1 DONE cycle.
- Strobes drop in the cycle after dmem_resp is seen (DONE).
- load_data_o is registered, valid in DONE only, and holds its value until the next capture.
- valid_i with neither load nor store: no stall, and the FSM does not leave IDLE.
- rst asserted in BUSY:
  - next edge forces IDLE and clears the strobes;
  - a late dmem_resp afterwards is ignored;
  - no load_valid_o is produced.
- A back-to-back memory instruction presented in the cycle after DONE starts a new access from IDLE.

## Configuration
- MEM_MISALIGN_CHECK_EN defined:
  - a misaligned access is any half with addr[0]=1, or any word with addr[1:0]≠0;
  - such an access skips BUSY (IDLE→DONE, one stall cycle);
  - no dmem strobe is issued;
  - misalign_o=1 during DONE only;
  - a misaligned load gives load_data_o=0 with load_valid_o=1.
- MEM_MISALIGN_CHECK_EN undefined:
  - misalign_o is tied 0;
  - ignored address bits: addr[0] for halves, addr[1:0] for words;
  - the access proceeds normally.

## Test plan
- SW addr=0x100, rs2=0xDEADBEEF, fwd=0, resp after 3 cycles:
  - dmem_write held 3 cycles, addr 0x100, mbe 1111, wdata 0xDEADBEEF;
  - stall_o high 4 cycles, then DONE.
- LB addr=0x203, rdata=0x80FF_FFFF:
  - load_data_o=0xFFFFFF80 in DONE;
  - the same access as LBU gives 0x00000080.
- SH addr=0x102, fwd=1, wb_data=0x0000_1234, rs2=0xFFFFFFFF:
  - mbe 1100, wdata 0x12341234.
- LW with resp on the first strobe cycle: exactly 2 stall cycles, then load_valid_o=1 for 1 cycle.
- rst pulsed while BUSY, then resp pulsed: FSM in IDLE, strobes 0, load_valid_o never asserted.
- MEM_MISALIGN_CHECK_EN, LW addr=0x101:
  - no strobe, 1 stall cycle, misalign_o=1, load_data_o=0;
  - without the macro: dmem_addr=0x100, normal load.
